// File: rtl/mips_cpu_mem_arbiter_if.sv
// rtl/mips_cpu_mem_arbiter_if.sv - CPU fetch/data request bus and unified memory bus
// The arbiter takes the slave view; the CPU-plus-memory environment takes the master view.
interface mips_cpu_mem_arbiter_if;
  logic        instr_req;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        instr_valid;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        data_valid;
  logic        stall;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  modport slave (
    input  instr_req, instr_address, data_read, data_write, data_address, data_writedata,
           mem_readdata,
    output instr_readdata, instr_valid, data_readdata, data_valid, stall,
           mem_address, mem_read, mem_write, mem_writedata
  );

  modport master (
    output instr_req, instr_address, data_read, data_write, data_address, data_writedata,
           mem_readdata,
    input  instr_readdata, instr_valid, data_readdata, data_valid, stall,
           mem_address, mem_read, mem_write, mem_writedata
  );
endinterface

// File: rtl/mips_cpu_mem_arbiter.sv
// rtl/mips_cpu_mem_arbiter.sv - single-port memory arbiter between CPU fetch and data sides
// Data side wins unless fetch has been passed over STARVE_LIMIT times in a row.
module mips_cpu_mem_arbiter #(
  parameter int          MEM_LATENCY  = 1,
  parameter int          STARVE_LIMIT = 4,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input logic                   clk,
  input logic                   reset,
  input logic                   clk_enable,
  mips_cpu_mem_arbiter_if.slave bus
);
  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D, DONE_I, DONE_D} state_t;

  state_t      state, state_nx;
  logic [2:0]  lat_cnt, lat_nx;
  logic [3:0]  starve_cnt, starve_nx;
  logic        op_write, op_write_nx;
  logic [31:0] addr_q, addr_nx;
  logic [31:0] wdata_q, wdata_nx;
  logic [31:0] irdata_q, irdata_nx;
  logic [31:0] drdata_q, drdata_nx;
  logic        data_req, data_wins, instr_valid_w, data_valid_w;

  assign data_req  = bus.data_read | bus.data_write;
  assign data_wins = data_req & (~bus.instr_req | (starve_cnt < STARVE_MAX));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      op_write   <= 1'b0;
      addr_q     <= RESET_VECTOR;
      wdata_q    <= '0;
      irdata_q   <= '0;
      drdata_q   <= '0;
    end else if (clk_enable) begin
      state      <= state_nx;
      lat_cnt    <= lat_nx;
      starve_cnt <= starve_nx;
      op_write   <= op_write_nx;
      addr_q     <= addr_nx;
      wdata_q    <= wdata_nx;
      irdata_q   <= irdata_nx;
      drdata_q   <= drdata_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    lat_nx      = lat_cnt;
    starve_nx   = starve_cnt;
    op_write_nx = op_write;
    addr_nx     = addr_q;
    wdata_nx    = wdata_q;
    irdata_nx   = irdata_q;
    drdata_nx   = drdata_q;
    case (state)
      IDLE: begin
        // Address and store word are latched at grant so a requester that drops early cannot disturb the access.
        if (data_wins) begin
          state_nx    = ISSUE_D;
          addr_nx     = bus.data_address;
          op_write_nx = bus.data_write;
          if (bus.data_write) wdata_nx = bus.data_writedata;
        end else if (bus.instr_req) begin
          state_nx = ISSUE_I;
          addr_nx  = bus.instr_address;
        end
      end
      ISSUE_I: begin
        lat_nx    = LAT_LOAD;
        starve_nx = '0;
        state_nx  = WAIT_I;
      end
      ISSUE_D: begin
        if (bus.instr_req) starve_nx = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
        else               starve_nx = '0;
        lat_nx   = LAT_LOAD;
        state_nx = op_write ? DONE_D : WAIT_D;
      end
      WAIT_I: begin
        if (lat_cnt == 3'd0) begin
          irdata_nx = bus.mem_readdata;
          state_nx  = DONE_I;
        end else begin
          lat_nx = lat_cnt - 3'd1;
        end
      end
      WAIT_D: begin
        if (lat_cnt == 3'd0) begin
          drdata_nx = bus.mem_readdata;
          state_nx  = DONE_D;
        end else begin
          lat_nx = lat_cnt - 3'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign instr_valid_w      = (state == DONE_I);
  assign data_valid_w       = (state == DONE_D);
  assign bus.instr_valid    = instr_valid_w;
  assign bus.data_valid     = data_valid_w;
  assign bus.instr_readdata = irdata_q;
  assign bus.data_readdata  = drdata_q;
  assign bus.mem_read       = (state == ISSUE_I) | ((state == ISSUE_D) & ~op_write);
  assign bus.mem_write      = (state == ISSUE_D) & op_write;
  assign bus.mem_address    = addr_q;
  assign bus.mem_writedata  = wdata_q;
  assign bus.stall          = reset & ((bus.instr_req & ~instr_valid_w) | (data_req & ~data_valid_w));
endmodule
